rr_hold_scheduler: RTL and testbench
====================================

# rr_hold_scheduler

Round-robin scheduler that shares one resource among N requesters with hold-until-release semantics and a bounded tenure. Extends the plain round-robin arbiter: a granted requester keeps the resource for as long as it holds its request, up to MAX_HOLD cycles. After MAX_HOLD cycles the scheduler preempts the owner if another requester is waiting. It sits between the requesting masters and the shared resource and drives the resource's select lines.

## Interface
- N, default 4: number of requesters, at least 2.
- MAX_HOLD, default 8: maximum consecutive grant cycles while contended, at least 1.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; when sampled high, all state is cleared at that edge.
- req  input  N  request vector; req[i] high means requester i wants the resource or is still using it.
- grant  output  N  registered grant, one-hot or zero.
- grant_valid  output  1  high when grant is non-zero; equals the OR of the grant bits.
- owner_id  output  $clog2(N)  index of the current owner; 0 when grant_valid is low.
- preempt  output  1  one-cycle pulse, registered; high in the first cycle after a timeout handover.

## Operation
- **Reset values:** grant=0, grant_valid=0, owner_id=0, preempt=0; internal ptr=0, hold_cnt=0, state=IDLE.
- **Priority pointer:** ptr names the highest-priority index. The search order is ptr, ptr+1, …, N-1, 0, …, ptr-1. Whenever a grant is issued to index k, ptr becomes (k+1) mod N, with wrap from N-1 to 0.
- **State IDLE (grant=0):**
  - req==0: stay in IDLE.
  - Otherwise: grant the first set req bit in search order, set hold_cnt=1, go to BUSY.
- **State BUSY (owner o, grant is the one-hot of o).** At each edge, evaluated in this priority order:
  1. req[o]==0 and other = req with bit o cleared is non-zero: hand over directly to the first set bit of other in search order. hold_cnt=1, preempt=0.
  2. req[o]==0 and other==0: grant=0, go to IDLE.
  3. req[o]==1, hold_cnt==MAX_HOLD and other!=0: preempt. Hand over to the first set bit of other in search order, hold_cnt=1, preempt=1 for one cycle.
  4. req[o]==1, hold_cnt==MAX_HOLD and other==0: owner keeps the grant, hold_cnt=1, no preempt.
  5. Otherwise: owner keeps the grant, hold_cnt increments.
- **Excluding the owner:** the outgoing owner is excluded from the handover search even if it is first in search order. Preemption therefore never re-grants the owner being preempted.
- **Non-owner requests:** req bits of non-owners may rise and fall freely; they affect only the next arbitration.
- **Counter:** hold_cnt width is $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD; there is no wrap.
- **MAX_HOLD=1:** under continuous contention this degenerates to per-cycle round-robin, with preempt high every cycle.
- **Invariant:** grant is $onehot0 in every cycle.

## Timing
- **Request to grant:** 1 cycle. req sampled at edge k produces grant visible after edge k. From IDLE there is no other latency.
- **Release latency:** the owner's grant drops at the first edge that samples req[o]=0. The requester therefore sees grant for one cycle after it lowers req.
- **Handover:** zero-bubble. The new grant appears at the same edge the old one drops, with no idle cycle between owners.
- **Maximum tenure:** under contention an owner holds grant for at most MAX_HOLD consecutive cycles.
- **Worst-case wait:** a waiting requester is granted within (N-1)·MAX_HOLD+1 cycles of raising req, provided it holds req.
- **preempt:** asserted exactly in the first cycle of the new owner's grant after a timeout handover. It is never asserted on a voluntary release.
- **Reset mid-operation:** reset sampled high clears grant at that edge regardless of state. The first grant after reset uses ptr=0.
- **Outputs:** all outputs are registered; there are no combinational paths from req to any output.

## Test plan
- **Reset:** hold reset for 2 cycles with req=1111 → grant=0000, owner_id=0, preempt=0 throughout. On the first edge after reset drops, grant=0001.
- **Single requester with release:** req=0010 for 5 cycles, then 0000 → grant=0010 from the cycle after req rises for 5 cycles, then 0000. preempt stays 0.
- **Full contention, MAX_HOLD=8:** req=1111 held for 40 cycles → grant sequence 0001 ×8, 0010 ×8, 0100 ×8, 1000 ×8, then 0001 (wrap). preempt pulses in the first cycle of each new owner after the first.
- **Voluntary handover:** owner 0 granted, req changes 0001→1010 → next cycle grant=0010 (ptr=1), no zero cycle, preempt=0. When bit 1 drops, grant=1000.
- **Lone long holder:** req=0100 for 20 cycles → grant=0100 continuously, preempt never asserted, hold_cnt stays within 1..8.
- **Reset mid-tenure:** owner 2 at hold_cnt=5, assert reset for 1 cycle with req=1111 → grant=0000 in the reset cycle, then grant=0001 with hold_cnt restarting at 1.

Source files
------------

// File: rtl/rr_hold_scheduler.sv
// Round-robin scheduler with hold-until-release ownership and bounded tenure.
// The owner keeps the resource while it requests, and is preempted after MAX_HOLD cycles if others wait.
module rr_hold_scheduler #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 preempt
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [N-1:0]       grant_r, grant_s;
    logic               valid_r;
    logic [IDX_W-1:0]   owner_r, owner_s;
    logic [IDX_W-1:0]   ptr_r, ptr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               preempt_r, preempt_s;
    logic [N-1:0]       other_s;
    logic [IDX_W-1:0]   pick_s;
    logic               owner_req_s;
    logic               at_max_s;

    // First set bit of v when scanning p, p+1, ..., N-1, 0, ..., p-1.
    function automatic logic [IDX_W-1:0] first_in_order(input logic [N-1:0] v,
                                                        input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   s;
        logic [IDX_W-1:0] r;
        r = p;
        for (int i = N - 1; i >= 0; i--) begin
            s = {1'b0, p} + (IDX_W+1)'(i);
            if (s >= (IDX_W+1)'(N)) begin
                s = s - (IDX_W+1)'(N);
            end else begin
                s = s;
            end
            if (v[s[IDX_W-1:0]]) begin
                r = s[IDX_W-1:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
        return (k == IDX_W'(N - 1)) ? IDX_W'(0) : k + IDX_W'(1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] k);
        return {{(N-1){1'b0}}, 1'b1} << k;
    endfunction

    // Arbitration inputs: grant_r is the owner's one-hot, so masking it excludes the outgoing owner.
    always_comb begin
        other_s     = req & ~grant_r;
        owner_req_s = |(req & grant_r);
        at_max_s    = (cnt_r == CNT_W'(MAX_HOLD));
        if (state_r == IDLE) begin
            pick_s = first_in_order(req, ptr_r);
        end else begin
            pick_s = first_in_order(other_s, ptr_r);
        end
    end

    // Next-state and next-output decision.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        owner_s   = owner_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        preempt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = BUSY;
                    grant_s = onehot(pick_s);
                    owner_s = pick_s;
                    ptr_s   = next_idx(pick_s);
                    cnt_s   = CNT_W'(1);
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!owner_req_s) begin
                    if (|other_s) begin
                        grant_s = onehot(pick_s);
                        owner_s = pick_s;
                        ptr_s   = next_idx(pick_s);
                        cnt_s   = CNT_W'(1);
                    end else begin
                        state_s = IDLE;
                        grant_s = {N{1'b0}};
                        owner_s = IDX_W'(0);
                        cnt_s   = CNT_W'(0);
                    end
                end else if (at_max_s) begin
                    // Tenure exhausted: hand over only if someone else is waiting.
                    if (|other_s) begin
                        grant_s   = onehot(pick_s);
                        owner_s   = pick_s;
                        ptr_s     = next_idx(pick_s);
                        cnt_s     = CNT_W'(1);
                        preempt_s = 1'b1;
                    end else begin
                        cnt_s = CNT_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = {N{1'b0}};
                owner_s = IDX_W'(0);
                ptr_s   = IDX_W'(0);
                cnt_s   = CNT_W'(0);
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            grant_r   <= {N{1'b0}};
            valid_r   <= 1'b0;
            owner_r   <= IDX_W'(0);
            ptr_r     <= IDX_W'(0);
            cnt_r     <= CNT_W'(0);
            preempt_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            valid_r   <= |grant_s;
            owner_r   <= owner_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            preempt_r <= preempt_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = valid_r;
    assign owner_id    = owner_r;
    assign preempt     = preempt_r;

endmodule

// File: tb/tb_rr_hold_scheduler.sv
// Self-checking bench for rr_hold_scheduler: vector table, directed corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_rr_hold_scheduler;
    localparam int N  = 4;
    localparam int MH = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] owner_id;
    logic       preempt;

    logic [3:0] req1;
    logic [3:0] grant1;
    logic       grant_valid1;
    logic [1:0] owner_id1;
    logic       preempt1;

    int checks = 0;
    int errors = 0;

    rr_hold_scheduler #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .grant_valid(grant_valid), .owner_id(owner_id), .preempt(preempt)
    );

    rr_hold_scheduler #(.N(N), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .grant(grant1),
        .grant_valid(grant_valid1), .owner_id(owner_id1), .preempt(preempt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner index (-1 = none), pointer, tenure count, preempt flag.
    int m_owner, m_ptr, m_cnt;
    bit m_pre;

    function automatic int search(input logic [3:0] v, input int p);
        for (int j = 0; j < N; j++) begin
            if (v[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] r);
        logic [3:0] other;
        int k;
        m_pre = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            k = search(r, m_ptr);
            if (k >= 0) begin
                m_owner = k; m_ptr = (k + 1) % N; m_cnt = 1;
            end
        end else begin
            other = r;
            other[m_owner] = 1'b0;
            k = search(other, m_ptr);
            if (!r[m_owner] || (m_cnt == MH && k >= 0)) begin
                m_pre = r[m_owner];
                if (k >= 0) begin
                    m_owner = k; m_ptr = (k + 1) % N; m_cnt = 1;
                end else begin
                    m_owner = -1; m_cnt = 0;
                end
            end else if (m_cnt == MH) begin
                m_cnt = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [1:0] exp_owner;
        logic       exp_pre;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] exp_g;

    initial begin
        // Release, re-request, voluntary handovers; pointer starts at 0 after reset.
        vecs[0] = '{4'b0010, 4'b0010, 2'd1, 1'b0};
        vecs[1] = '{4'b0010, 4'b0010, 2'd1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[3] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        vecs[4] = '{4'b1010, 4'b0010, 2'd1, 1'b0};
        vecs[5] = '{4'b1000, 4'b1000, 2'd3, 1'b0};
        vecs[6] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[7] = '{4'b0100, 4'b0100, 2'd2, 1'b0};

        req1  = 4'b1111;
        reset = 1'b1;
        req   = 4'b1111;
        #1;

        // Reset held two cycles with all requests active.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset_grant", grant, 4'b0000);
            chk("reset_valid", grant_valid, 1'b0);
            chk("reset_owner", owner_id, 2'd0);
            chk("reset_preempt", preempt, 1'b0);
            chk("reset_grant_mh1", grant1, 4'b0000);
        end
        reset = 1'b0;

        // Full contention: 8-cycle tenures rotating; MAX_HOLD=1 rotates every cycle.
        for (int c = 0; c < 40; c++) begin
            tick();
            exp_g = 4'b0001 << ((c / MH) % N);
            chk("contend_grant", grant, exp_g);
            chk("contend_preempt", preempt, (c > 0 && c % MH == 0) ? 1 : 0);
            chk("contend_owner", owner_id, (c / MH) % N);
            exp_g = 4'b0001 << (c % N);
            chk("mh1_grant", grant1, exp_g);
            chk("mh1_preempt", preempt1, (c > 0) ? 1 : 0);
        end

        // Vector table from a clean reset.
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            tick();
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            chk($sformatf("vec%0d_owner", i), owner_id, vecs[i].exp_owner);
            chk($sformatf("vec%0d_preempt", i), preempt, vecs[i].exp_pre);
            chk($sformatf("vec%0d_valid", i), grant_valid, (vecs[i].exp_grant != 0) ? 1 : 0);
        end

        // Lone long holder: never preempted, count stays in 1..MAX_HOLD.
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0; req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("lone_grant", grant, 4'b0100);
            chk("lone_preempt", preempt, 1'b0);
            chk("lone_cnt_range", (dut.cnt_r >= 1 && dut.cnt_r <= MH) ? 1 : 0, 1);
            chk("lone_cnt", dut.cnt_r, (c % MH) + 1);
        end

        // Reset mid-tenure: owner 2 at count 5, one reset cycle, then restart from ptr 0.
        reset = 1'b1; req = 4'b0000;
        tick();
        reset = 1'b0; req = 4'b0100;
        for (int c = 0; c < 5; c++) tick();
        chk("mid_owner", owner_id, 2'd2);
        chk("mid_cnt", dut.cnt_r, 5);
        reset = 1'b1; req = 4'b1111;
        tick();
        chk("mid_reset_grant", grant, 4'b0000);
        reset = 1'b0;
        tick();
        chk("mid_after_grant", grant, 4'b0001);
        chk("mid_after_cnt", dut.cnt_r, 1);

        // Randomized traffic against the reference model.
        req = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] mask;
            logic rst;
            rst = (c == 0) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) begin
                req = 4'b1111;
            end else begin
                for (int b = 0; b < N; b++) mask[b] = ($urandom_range(0, 5) == 0);
                req = req ^ mask;
            end
            reset = rst;
            model_step(rst, req);
            tick();
            exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            chk("rnd_grant", grant, exp_g);
            chk("rnd_valid", grant_valid, (m_owner >= 0) ? 1 : 0);
            chk("rnd_owner", owner_id, (m_owner >= 0) ? m_owner : 0);
            chk("rnd_preempt", preempt, m_pre);
            chk("rnd_cnt", dut.cnt_r, m_cnt);
            chk("rnd_onehot0", $onehot0(grant) ? 1 : 0, 1);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
